// File: rtl/combo_pkg.sv
// Shared definitions for the combination entry checker: FSM state encoding,
// the digit width and a helper that extracts one digit from a packed code.
package combo_pkg;

  localparam int DIGIT_W    = 4;
  localparam int CODE_MAX_W = 64;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    FAIL     = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  // Digit i of a right-justified code of code_len digits, counted MSB-first
  // (i = 0 is the first digit the user enters).
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_MAX_W-1:0] code,
                                                    input int code_len,
                                                    input int i);
    return code[(code_len-1-i)*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/combo_entry_checker_if.sv
// Digit/strobe bundle between the digit counter side and the checker, plus the
// checker's status outputs. The checker uses the slave modport.
interface combo_entry_checker_if #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 4
);
  localparam int IDX_W = $clog2(CODE_LEN);

  logic [DIGIT_W-1:0] digit;
  logic               enter;
  logic               clear;
  logic               relock;
  logic               unlocked;
  logic               error;
  logic               locked_out;
  logic [IDX_W-1:0]   idx;
  logic               count_clr;

  modport master (
    output digit, enter, clear, relock,
    input  unlocked, error, locked_out, idx, count_clr
  );

  modport slave (
    input  digit, enter, clear, relock,
    output unlocked, error, locked_out, idx, count_clr
  );
endinterface

// File: rtl/combo_entry_checker_lockout_timer.sv
// Down-counter for the lockout period: load sets it to CYCLES-1, it then counts
// down to 0 and holds there; done is high whenever the count is 0.
module lockout_timer #(
  parameter int CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam int TW = $clog2(CYCLES);

  logic [TW-1:0] count;

  // Load on request, otherwise count down until 0.
  // NOTE: reset is synchronous, so rst is tested inside the clocked block and
  // only takes effect on a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(CYCLES - 1);
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/combo_entry_checker.sv
// Checks a digit sequence sampled from the up/down counter against a fixed
// code. Drives unlocked/error/locked_out indicators, clears the counter after
// every accepted digit and locks out after MAX_FAILS consecutive failures.
module combo_entry_checker
  import combo_pkg::*;
#(
  parameter int                          DIGIT_W        = combo_pkg::DIGIT_W,
  parameter int                          CODE_LEN       = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] CODE           = 16'h1234,
  parameter int                          MAX_FAILS      = 3,
  parameter int                          LOCKOUT_CYCLES = 50000000
) (
  input logic                  clk,
  input logic                  rst,
  combo_entry_checker_if.slave bus
);
  localparam int                  IW       = $clog2(CODE_LEN);
  localparam int                  FW       = $clog2(MAX_FAILS + 1);
  localparam logic [IW-1:0]       LAST_IDX = IW'(CODE_LEN - 1);
  localparam logic [CODE_MAX_W-1:0] CODE_EXT = CODE_MAX_W'(CODE);

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          mismatch, mismatch_n;
  logic [FW-1:0] fail_cnt, fail_cnt_n;
  logic          clr_n;
  logic          digit_bad;
  logic          timer_load;
  logic          timer_done;

  logic          unlocked_q, error_q, locked_out_q, count_clr_q;

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  // Next-state, digit compare and counter-clear decision.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mismatch_n = mismatch;
    fail_cnt_n = fail_cnt;
    clr_n      = 1'b0;
    timer_load = 1'b0;
    digit_bad  = (bus.digit != code_digit(CODE_EXT, CODE_LEN, int'(idx)));

    case (state)
      ENTRY: begin
        if (bus.clear) begin
          // Abort wins over a simultaneous enter; not counted as a failure.
          idx_n      = '0;
          mismatch_n = 1'b0;
          clr_n      = 1'b1;
        end else if (bus.enter) begin
          clr_n = 1'b1;
          if (idx == LAST_IDX) begin
            idx_n      = '0;
            mismatch_n = 1'b0;
            if (mismatch || digit_bad) begin
              state_n = FAIL;
            end else begin
              state_n    = UNLOCKED;
              fail_cnt_n = '0;
            end
          end else begin
            // Mismatches are only accumulated, never revealed early.
            idx_n      = idx + IW'(1);
            mismatch_n = mismatch | digit_bad;
          end
        end
      end
      FAIL: begin
        if (fail_cnt == FW'(MAX_FAILS - 1)) begin
          state_n    = LOCKOUT;
          timer_load = 1'b1;
          fail_cnt_n = '0;
        end else begin
          state_n    = ENTRY;
          fail_cnt_n = fail_cnt + FW'(1);
        end
      end
      UNLOCKED: begin
        if (bus.relock) begin
          state_n = ENTRY;
          clr_n   = 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_done) state_n = ENTRY;
      end
      default: state_n = ENTRY;
    endcase
  end

  // State registers and registered outputs decoded from the next state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ENTRY;
      idx          <= '0;
      mismatch     <= 1'b0;
      fail_cnt     <= '0;
      unlocked_q   <= 1'b0;
      error_q      <= 1'b0;
      locked_out_q <= 1'b0;
      count_clr_q  <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      mismatch     <= mismatch_n;
      fail_cnt     <= fail_cnt_n;
      unlocked_q   <= (state_n == UNLOCKED);
      error_q      <= (state_n == FAIL);
      locked_out_q <= (state_n == LOCKOUT);
      count_clr_q  <= clr_n;
    end
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.error      = error_q;
  assign bus.locked_out = locked_out_q;
  assign bus.idx        = idx;
  assign bus.count_clr  = count_clr_q;
endmodule

// File: tb/tb_combo_entry_checker.sv
// Directed bench for combo_entry_checker with CODE=1234, MAX_FAILS=3 and an
// 8-cycle lockout. A vector table covers the basic flows; hand-written
// sequences cover lockout length and mid-operation reset.
module tb_combo_entry_checker;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  combo_entry_checker_if #(.DIGIT_W(4), .CODE_LEN(4)) bus ();

  combo_entry_checker #(
    .DIGIT_W        (4),
    .CODE_LEN       (4),
    .CODE           (16'h1234),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       enter;
    logic       clear;
    logic       relock;
    logic [3:0] digit;
    logic       u;
    logic       e;
    logic       l;
    logic       c;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic r, input logic en, input logic cl,
                     input logic rl, input logic [3:0] d, input logic u, input logic e,
                     input logic l, input logic c, input logic [1:0] ix);
    vec_t v;
    v.name = n; v.rst = r; v.enter = en; v.clear = cl; v.relock = rl; v.digit = d;
    v.u = u; v.e = e; v.l = l; v.c = c; v.idx = ix;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    rst        = 1'b0;
    bus.enter  = 1'b0;
    bus.clear  = 1'b0;
    bus.relock = 1'b0;
    bus.digit  = 4'd0;
  endtask

  // Apply one row for one clock edge and compare outputs 1 time unit later.
  task automatic apply(input vec_t v);
    rst        = v.rst;
    bus.enter  = v.enter;
    bus.clear  = v.clear;
    bus.relock = v.relock;
    bus.digit  = v.digit;
    @(posedge clk);
    #1;
    idle_inputs();
    check({v.name, ".unlocked"},   32'(bus.unlocked),   32'(v.u));
    check({v.name, ".error"},      32'(bus.error),      32'(v.e));
    check({v.name, ".locked_out"}, 32'(bus.locked_out), 32'(v.l));
    check({v.name, ".count_clr"},  32'(bus.count_clr),  32'(v.c));
    check({v.name, ".idx"},        32'(bus.idx),        32'(v.idx));
  endtask

  task automatic row(input string n, input logic r, input logic en, input logic cl,
                     input logic rl, input logic [3:0] d, input logic u, input logic e,
                     input logic l, input logic c, input logic [1:0] ix);
    vec_t v;
    v.name = n; v.rst = r; v.enter = en; v.clear = cl; v.relock = rl; v.digit = d;
    v.u = u; v.e = e; v.l = l; v.c = c; v.idx = ix;
    apply(v);
  endtask

  // Four enters of a packed code; the last one must unlock (ok) or fail.
  task automatic enter_code(input string n, input logic [15:0] code, input bit ok);
    logic [15:0] cw;
    cw = code;
    for (int i = 0; i < 3; i++)
      row($sformatf("%s.d%0d", n, i), 0, 1, 0, 0, cw[15-4*i -: 4], 0, 0, 0, 1, 2'(i + 1));
    row($sformatf("%s.d3", n), 0, 1, 0, 0, cw[3:0], ok, !ok, 0, 1, 2'd0);
  endtask

  // Three failed attempts ending on the cycle where error pulses for the third.
  task automatic three_fails(input string n);
    enter_code({n, ".f1"}, 16'h1235, 0);
    row({n, ".f1idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    enter_code({n, ".f2"}, 16'hA234, 0);
    row({n, ".f2idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    enter_code({n, ".f3"}, 16'h0000, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int locked_cycles;

    idle_inputs();
    rst = 1'b1;

    //          name         rst en cl rl dig  u  e  l  c  idx
    add("reset",              1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    // Correct entry, unlock, relock.
    add("t1.d1",              0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t1.d2",              0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    add("t1.d3",              0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 3);
    add("t1.d4",              0, 1, 0, 0, 4'd4, 1, 0, 0, 1, 0);
    add("t1.hold",            0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    add("t1.enter_ignored",   0, 1, 0, 0, 4'd1, 1, 0, 0, 0, 0);
    add("t1.relock",          0, 0, 0, 1, 4'd0, 0, 0, 0, 1, 0);
    add("t1.idle",            0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    // Wrong second digit: no early error, one error pulse at the end.
    add("t2.d1",              0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t2.d2bad",           0, 1, 0, 0, 4'd9, 0, 0, 0, 1, 2);
    add("t2.d3",              0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 3);
    add("t2.d4",              0, 1, 0, 0, 4'd4, 0, 1, 0, 1, 0);
    add("t2.after",           0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    add("t2.after2",          0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    // Clear mid-entry is not a failure; correct entry still unlocks.
    add("t4.d1",              0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t4.d2",              0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    add("t4.clear",           0, 0, 1, 0, 4'd0, 0, 0, 0, 1, 0);
    add("t4.c1",              0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t4.c2",              0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    add("t4.c3",              0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 3);
    add("t4.c4",              0, 1, 0, 0, 4'd4, 1, 0, 0, 1, 0);
    add("t4.relock",          0, 0, 0, 1, 4'd0, 0, 0, 0, 1, 0);
    // Same-cycle clear+enter: clear wins, digit dropped.
    add("t4b.d1",             0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t4b.clr_enter",      0, 1, 1, 0, 4'd2, 0, 0, 0, 1, 0);
    add("t4b.c1",             0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t4b.c2",             0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    add("t4b.c3",             0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 3);
    add("t4b.c4",             0, 1, 0, 0, 4'd4, 1, 0, 0, 1, 0);
    add("t4b.relock",         0, 0, 0, 1, 4'd0, 0, 0, 0, 1, 0);
    // Two failures, success, one failure: no lockout.
    add("t5.a1",              0, 1, 0, 0, 4'd4, 0, 0, 0, 1, 1);
    add("t5.a2",              0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 2);
    add("t5.a3",              0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 3);
    add("t5.a4",              0, 1, 0, 0, 4'd1, 0, 1, 0, 1, 0);
    add("t5.a_idle",          0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    add("t5.b1",              0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t5.b2",              0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    add("t5.b3",              0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 3);
    add("t5.b4bad",           0, 1, 0, 0, 4'hF, 0, 1, 0, 1, 0);
    add("t5.b_idle",          0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    add("t5.ok1",             0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    add("t5.ok2",             0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    add("t5.ok3",             0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 3);
    add("t5.ok4",             0, 1, 0, 0, 4'd4, 1, 0, 0, 1, 0);
    add("t5.relock",          0, 0, 0, 1, 4'd0, 0, 0, 0, 1, 0);
    add("t5.c1",              0, 1, 0, 0, 4'd0, 0, 0, 0, 1, 1);
    add("t5.c2",              0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    add("t5.c3",              0, 1, 0, 0, 4'd3, 0, 0, 0, 1, 3);
    add("t5.c4",              0, 1, 0, 0, 4'd4, 0, 1, 0, 1, 0);
    add("t5.no_lockout",      0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    add("t5.no_lockout2",     0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Lockout length and dropped enters during FAIL/LOCKOUT.
    row("t3.reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    three_fails("t3");
    locked_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      bus.enter = 1'b1;
      bus.digit = 4'd1;
      @(posedge clk);
      #1;
      idle_inputs();
      if (bus.locked_out !== 1'b1) break;
      locked_cycles++;
      check($sformatf("t3.lock%0d.idx", i), 32'(bus.idx), 32'd0);
      check($sformatf("t3.lock%0d.count_clr", i), 32'(bus.count_clr), 32'd0);
      check($sformatf("t3.lock%0d.error", i), 32'(bus.error), 32'd0);
    end
    check("t3.lockout_cycles", 32'(locked_cycles), 32'd8);
    check("t3.exit.idx", 32'(bus.idx), 32'd0);
    check("t3.exit.count_clr", 32'(bus.count_clr), 32'd0);
    enter_code("t3.unlock", 16'h1234, 1);
    row("t3.relock", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

    // Reset during lockout.
    three_fails("t6a");
    row("t6a.lk1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    row("t6a.lk2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    row("t6a.rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row("t6a.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    enter_code("t6a.unlock", 16'h1234, 1);
    row("t6a.relock", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

    // Reset mid-entry at idx=2, with an enter on the same edge.
    row("t6b.d1", 0, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1);
    row("t6b.d2", 0, 1, 0, 0, 4'd2, 0, 0, 0, 1, 2);
    row("t6b.rst", 1, 1, 0, 0, 4'd3, 0, 0, 0, 0, 0);
    enter_code("t6b.unlock", 16'h1234, 1);
    row("t6b.relock", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
